// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants and framebuffer helpers for the scan-out path
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W      = 10;
    localparam int SCALE_LOG2 = 2;
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int FB_ADDR_W  = 15;
    localparam int COLOR_W    = 3;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t BLACK   = 3'b000;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t WHITE   = 3'b111;
    localparam color_t RED     = 3'b100;

    // y*160 + x as y*128 + y*32 + x, keeping the address path multiplier-free
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = {{(FB_ADDR_W-7){1'b0}}, y};
        return (yw << 7) + (yw << 5) + {{(FB_ADDR_W-8){1'b0}}, x};
    endfunction

    function automatic logic [23:0] color_expand(input color_t c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// rtl/vga_fb_scanout_if.sv - framebuffer read port between scan-out (master) and pixel memory (slave)
interface vga_fb_scanout_if;
    import vga_pkg::*;

    logic                 rd_en;
    logic [FB_ADDR_W-1:0] rd_addr;
    logic [COLOR_W-1:0]   rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);

endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v counters with active, sync, vblank and frame_start decode
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    output logic [vga_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_pkg::CNT_W-1:0] v_cnt,
    output logic                     active,
    output logic                     hs_raw,
    output logic                     vs_raw,
    output logic                     vblank,
    output logic                     frame_start
);
    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Gating with enable lets the downstream pipeline flush to blank while counters sit at 0
    assign active = enable && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw = !enable || !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_raw = !enable || !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            vblank      <= (v_cnt >= V_VIS);
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - 160x120 framebuffer scan-out to 640x480 VGA with 4x4 pixel scaling
module vga_fb_scanout #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    vga_fb_scanout_if.master  fb,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              vblank,
    output logic              frame_start
);
    import vga_pkg::*;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic             hs_0, vs_0;
    logic             act_1, hs_1, vs_1;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    assign vga_sync_n = 1'b0;

    // rd_en doubles as the stage-0 active bit; sync terms travel alongside so nothing skews
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb.rd_en    <= 1'b0;
            fb.rd_addr  <= '0;
            hs_0        <= 1'b1;
            vs_0        <= 1'b1;
            act_1       <= 1'b0;
            hs_1        <= 1'b1;
            vs_1        <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            fb.rd_en <= active;
            if (active) begin
                fb.rd_addr <= fb_addr(h_cnt[SCALE_LOG2 +: 8], v_cnt[SCALE_LOG2 +: 7]);
            end
            hs_0 <= hs_raw;
            vs_0 <= vs_raw;

            act_1 <= fb.rd_en;
            hs_1  <= hs_0;
            vs_1  <= vs_0;

            {vga_r, vga_g, vga_b} <= act_1 ? color_expand(fb.rd_data) : color_expand(BLACK);
            vga_blank_n           <= act_1;
            vga_hs                <= hs_1;
            vga_vs                <= vs_1;
        end
    end

endmodule
